// File: rtl/gcn_edge_aggregator.sv
// gcn_edge_aggregator
//   Sums transformed feature rows (FM*WM) over each node's COO neighbours,
//   optionally seeded with the node's own row, then emits the argmax class
//   per node.
//
// Ports
//   clk              rising-edge clock
//   reset            asynchronous, active-low reset
//   start            one-cycle run request, honoured in IDLE/DONE only
//   coo_address      edge index to COO memory
//   coo_in[0:1]      {src, dst} returned one cycle after coo_address
//   read_row/read_en FM*WM row request
//   fm_wm_row[]      row data returned one cycle after read_en
//   busy/done/err    run status; err is sticky for the run (bad node index)
//   max_addi_answer  argmax class index per node
module gcn_edge_aggregator #(
  parameter int unsigned NUM_OF_NODES   = 6,
  parameter int unsigned NUM_OF_EDGES   = 6,
  parameter int unsigned NUM_CLASSES    = 3,
  parameter int unsigned DOT_PROD_WIDTH = 16,
  parameter int unsigned SELF_LOOP      = 1,
  parameter int unsigned UNDIRECTED     = 1,
  parameter int unsigned SATURATE       = 1,
  parameter int unsigned NODE_BW        = $clog2(NUM_OF_NODES),
  parameter int unsigned EDGE_BW        = $clog2(NUM_OF_EDGES),
  parameter int unsigned CLASS_BW       = $clog2(NUM_CLASSES)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  output logic [EDGE_BW-1:0]        coo_address,
  input  logic [NODE_BW-1:0]        coo_in [0:1],
  output logic [NODE_BW-1:0]        read_row,
  output logic                      read_en,
  input  logic [DOT_PROD_WIDTH-1:0] fm_wm_row [0:NUM_CLASSES-1],
  output logic                      busy,
  output logic                      done,
  output logic                      err,
  output logic [CLASS_BW-1:0]       max_addi_answer [0:NUM_OF_NODES-1]
);

  localparam logic [NODE_BW-1:0] LAST_NODE = NODE_BW'(NUM_OF_NODES - 1);
  localparam logic [EDGE_BW-1:0] LAST_EDGE = EDGE_BW'(NUM_OF_EDGES - 1);

  typedef enum logic [3:0] {
    IDLE, SELF_RD, SELF_ACC, E_ADDR, E_SRC, E_DST, E_REV, ARGMAX, DONE
  } state_t;

  state_t                    state;
  logic [NODE_BW-1:0]        n;
  logic [EDGE_BW-1:0]        e;
  logic [NODE_BW-1:0]        src_q;
  logic [NODE_BW-1:0]        dst_q;
  logic [NODE_BW-1:0]        read_row_q;
  logic [EDGE_BW-1:0]        coo_address_q;
  logic [DOT_PROD_WIDTH-1:0] acc [0:NUM_OF_NODES-1][0:NUM_CLASSES-1];

  logic                      coo_oor;
  logic                      rev_needed;
  logic [CLASS_BW-1:0]       best_idx;
  logic [DOT_PROD_WIDTH-1:0] best_val;

  function automatic logic [DOT_PROD_WIDTH-1:0] acc_add(
    input logic [DOT_PROD_WIDTH-1:0] a,
    input logic [DOT_PROD_WIDTH-1:0] b
  );
    logic [DOT_PROD_WIDTH:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (SATURATE != 0 && s[DOT_PROD_WIDTH])
      return '1;
    return s[DOT_PROD_WIDTH-1:0];
  endfunction

  assign coo_oor    = (32'(coo_in[0]) >= NUM_OF_NODES) ||
                      (32'(coo_in[1]) >= NUM_OF_NODES);
  assign rev_needed = (UNDIRECTED != 0) && (src_q != dst_q);

  // Memory requests are decoded from state so the src row can be requested
  // in the same cycle coo_in arrives; this keeps a directed edge at three
  // cycles. Addresses hold their last value when not requesting.
  always_comb begin
    read_en     = 1'b0;
    read_row    = read_row_q;
    coo_address = coo_address_q;
    case (state)
      SELF_RD: begin
        read_en  = 1'b1;
        read_row = n;
      end
      E_ADDR: coo_address = e;
      E_SRC: begin
        if (!coo_oor) begin
          read_en  = 1'b1;
          read_row = coo_in[0];
        end
      end
      E_DST: begin
        if (rev_needed) begin
          read_en  = 1'b1;
          read_row = dst_q;
        end
      end
      default: ;
    endcase
  end

  // Strict '>' keeps the lowest class index on ties.
  always_comb begin
    best_idx = '0;
    best_val = acc[n][0];
    for (int unsigned c = 1; c < NUM_CLASSES; c++) begin
      if (acc[n][c] > best_val) begin
        best_val = acc[n][c];
        best_idx = CLASS_BW'(c);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      n             <= '0;
      e             <= '0;
      src_q         <= '0;
      dst_q         <= '0;
      read_row_q    <= '0;
      coo_address_q <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      err           <= 1'b0;
      for (int unsigned i = 0; i < NUM_OF_NODES; i++) begin
        max_addi_answer[i] <= '0;
        for (int unsigned c = 0; c < NUM_CLASSES; c++)
          acc[i][c] <= '0;
      end
    end else begin
      read_row_q    <= read_row;
      coo_address_q <= coo_address;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            for (int unsigned i = 0; i < NUM_OF_NODES; i++)
              for (int unsigned c = 0; c < NUM_CLASSES; c++)
                acc[i][c] <= '0;
            err   <= 1'b0;
            n     <= '0;
            e     <= '0;
            busy  <= 1'b1;
            done  <= 1'b0;
            state <= (SELF_LOOP != 0) ? SELF_RD : E_ADDR;
          end
        end
        SELF_RD: state <= SELF_ACC;
        SELF_ACC: begin
          for (int unsigned c = 0; c < NUM_CLASSES; c++)
            acc[n][c] <= fm_wm_row[c];
          if (n == LAST_NODE) begin
            n     <= '0;
            state <= E_ADDR;
          end else begin
            n     <= n + 1'b1;
            state <= SELF_RD;
          end
        end
        E_ADDR: state <= E_SRC;
        E_SRC: begin
          src_q <= coo_in[0];
          dst_q <= coo_in[1];
          if (coo_oor) begin
            err <= 1'b1;
            if (e == LAST_EDGE) begin
              n     <= '0;
              state <= ARGMAX;
            end else begin
              e     <= e + 1'b1;
              state <= E_ADDR;
            end
          end else begin
            state <= E_DST;
          end
        end
        E_DST: begin
          for (int unsigned c = 0; c < NUM_CLASSES; c++)
            acc[dst_q][c] <= acc_add(acc[dst_q][c], fm_wm_row[c]);
          if (rev_needed) begin
            state <= E_REV;
          end else if (e == LAST_EDGE) begin
            n     <= '0;
            state <= ARGMAX;
          end else begin
            e     <= e + 1'b1;
            state <= E_ADDR;
          end
        end
        E_REV: begin
          for (int unsigned c = 0; c < NUM_CLASSES; c++)
            acc[src_q][c] <= acc_add(acc[src_q][c], fm_wm_row[c]);
          if (e == LAST_EDGE) begin
            n     <= '0;
            state <= ARGMAX;
          end else begin
            e     <= e + 1'b1;
            state <= E_ADDR;
          end
        end
        ARGMAX: begin
          max_addi_answer[n] <= best_idx;
          if (n == LAST_NODE) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end else begin
            n <= n + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gcn_edge_aggregator.sv
// Directed bench for gcn_edge_aggregator: four parameter variants share
// clock, reset and the COO/row tables; each has its own one-cycle-latency
// memory model.
module tb_gcn_edge_aggregator;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;

  logic [2:0]  esrc [0:7];
  logic [2:0]  edst [0:7];
  logic [15:0] rows [0:7][0:2];

  // d: directed, saturating   u: undirected   t: no self-loop, undirected
  // w: directed, wrapping
  logic d_start = 1'b0, u_start = 1'b0, t_start = 1'b0, w_start = 1'b0;
  logic [2:0]  d_coo_address, u_coo_address, t_coo_address, w_coo_address;
  logic [2:0]  d_coo_in [0:1], u_coo_in [0:1], t_coo_in [0:1], w_coo_in [0:1];
  logic [2:0]  d_read_row, u_read_row, t_read_row, w_read_row;
  logic        d_read_en, u_read_en, t_read_en, w_read_en;
  logic [15:0] d_row [0:2], u_row [0:2], t_row [0:2], w_row [0:2];
  logic        d_busy, u_busy, t_busy, w_busy;
  logic        d_done, u_done, t_done, w_done;
  logic        d_err, u_err, t_err, w_err;
  logic [1:0]  d_ans [0:5], u_ans [0:5], t_ans [0:5], w_ans [0:5];

  gcn_edge_aggregator #(.UNDIRECTED(0), .SELF_LOOP(1), .SATURATE(1)) dut_d (
    .clk(clk), .reset(reset), .start(d_start), .coo_address(d_coo_address),
    .coo_in(d_coo_in), .read_row(d_read_row), .read_en(d_read_en),
    .fm_wm_row(d_row), .busy(d_busy), .done(d_done), .err(d_err),
    .max_addi_answer(d_ans));

  gcn_edge_aggregator #(.UNDIRECTED(1), .SELF_LOOP(1), .SATURATE(1)) dut_u (
    .clk(clk), .reset(reset), .start(u_start), .coo_address(u_coo_address),
    .coo_in(u_coo_in), .read_row(u_read_row), .read_en(u_read_en),
    .fm_wm_row(u_row), .busy(u_busy), .done(u_done), .err(u_err),
    .max_addi_answer(u_ans));

  gcn_edge_aggregator #(.UNDIRECTED(1), .SELF_LOOP(0), .SATURATE(1)) dut_t (
    .clk(clk), .reset(reset), .start(t_start), .coo_address(t_coo_address),
    .coo_in(t_coo_in), .read_row(t_read_row), .read_en(t_read_en),
    .fm_wm_row(t_row), .busy(t_busy), .done(t_done), .err(t_err),
    .max_addi_answer(t_ans));

  gcn_edge_aggregator #(.UNDIRECTED(0), .SELF_LOOP(1), .SATURATE(0)) dut_w (
    .clk(clk), .reset(reset), .start(w_start), .coo_address(w_coo_address),
    .coo_in(w_coo_in), .read_row(w_read_row), .read_en(w_read_en),
    .fm_wm_row(w_row), .busy(w_busy), .done(w_done), .err(w_err),
    .max_addi_answer(w_ans));

  always @(posedge clk) begin
    d_coo_in[0] <= esrc[d_coo_address];
    d_coo_in[1] <= edst[d_coo_address];
    if (d_read_en) for (int c = 0; c < 3; c++) d_row[c] <= rows[d_read_row][c];
  end
  always @(posedge clk) begin
    u_coo_in[0] <= esrc[u_coo_address];
    u_coo_in[1] <= edst[u_coo_address];
    if (u_read_en) for (int c = 0; c < 3; c++) u_row[c] <= rows[u_read_row][c];
  end
  always @(posedge clk) begin
    t_coo_in[0] <= esrc[t_coo_address];
    t_coo_in[1] <= edst[t_coo_address];
    if (t_read_en) for (int c = 0; c < 3; c++) t_row[c] <= rows[t_read_row][c];
  end
  always @(posedge clk) begin
    w_coo_in[0] <= esrc[w_coo_address];
    w_coo_in[1] <= edst[w_coo_address];
    if (w_read_en) for (int c = 0; c < 3; c++) w_row[c] <= rows[w_read_row][c];
  end

  task automatic set_start(input int which, input logic v);
    case (which)
      0: d_start = v;
      1: u_start = v;
      2: t_start = v;
      default: w_start = v;
    endcase
  endtask

  function automatic logic get_done(input int which);
    case (which)
      0: return d_done;
      1: return u_done;
      2: return t_done;
      default: return w_done;
    endcase
  endfunction

  function automatic logic get_busy(input int which);
    case (which)
      0: return d_busy;
      1: return u_busy;
      2: return t_busy;
      default: return w_busy;
    endcase
  endfunction

  // Cycle 0 is the cycle start is sampled in; cyc is the cycle index seen
  // #1 after each edge. Stops at done, at abort_at (reset asserted), or at
  // a 200-cycle bound.
  task automatic run(input int which, input int pulse_at, input int abort_at,
                     output int cyc, output logic busy1);
    @(negedge clk);
    set_start(which, 1'b1);
    @(posedge clk);
    #1;
    set_start(which, 1'b0);
    cyc   = 1;
    busy1 = get_busy(which);
    while (cyc < 200) begin
      if (get_done(which)) break;
      if (cyc == abort_at) begin
        reset = 1'b0;
        #1;
        break;
      end
      if (cyc == pulse_at) set_start(which, 1'b1);
      else if (cyc == pulse_at + 1) set_start(which, 1'b0);
      @(posedge clk);
      #1;
      cyc++;
    end
  endtask

  task automatic load_chain();
    for (int i = 0; i < 8; i++) begin
      esrc[i] = 3'(i % 6);
      edst[i] = 3'((i + 1) % 6);
      rows[i][0] = 16'(i);
      rows[i][1] = 16'(2 * i);
      rows[i][2] = 16'(3 * i);
    end
  endtask

  task automatic test_reset();
    #12;
    total++; if (d_busy !== 1'b0) $display("FAIL reset_busy: got %0d expected 0", d_busy); else passed++;
    total++; if (d_done !== 1'b0) $display("FAIL reset_done: got %0d expected 0", d_done); else passed++;
    total++; if (d_err !== 1'b0) $display("FAIL reset_err: got %0d expected 0", d_err); else passed++;
    total++; if (d_read_en !== 1'b0) $display("FAIL reset_read_en: got %0d expected 0", d_read_en); else passed++;
    total++; if (d_coo_address !== 3'd0) $display("FAIL reset_coo_address: got %0d expected 0", d_coo_address); else passed++;
    total++; if (d_read_row !== 3'd0) $display("FAIL reset_read_row: got %0d expected 0", d_read_row); else passed++;
    for (int i = 0; i < 6; i++) begin
      total++; if (d_ans[i] !== 2'd0) $display("FAIL reset_answer[%0d]: got %0d expected 0", i, d_ans[i]); else passed++;
    end
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_directed();
    int cyc; logic b1;
    load_chain();
    run(0, -1, -1, cyc, b1);
    total++; if (cyc !== 37) $display("FAIL dir_done_cycle: got %0d expected 37", cyc); else passed++;
    total++; if (b1 !== 1'b1) $display("FAIL dir_busy_c1: got %0d expected 1", b1); else passed++;
    total++; if (d_busy !== 1'b0) $display("FAIL dir_busy_at_done: got %0d expected 0", d_busy); else passed++;
    total++; if (d_err !== 1'b0) $display("FAIL dir_err: got %0d expected 0", d_err); else passed++;
    for (int c = 0; c < 3; c++) begin
      total++; if (dut_d.acc[1][c] !== 16'(c + 1)) $display("FAIL dir_acc1[%0d]: got %0d expected %0d", c, dut_d.acc[1][c], c + 1); else passed++;
      total++; if (dut_d.acc[0][c] !== 16'(5 * (c + 1))) $display("FAIL dir_acc0[%0d]: got %0d expected %0d", c, dut_d.acc[0][c], 5 * (c + 1)); else passed++;
    end
    for (int i = 0; i < 6; i++) begin
      total++; if (d_ans[i] !== 2'd2) $display("FAIL dir_answer[%0d]: got %0d expected 2", i, d_ans[i]); else passed++;
    end
  endtask

  task automatic test_undirected();
    int cyc; logic b1;
    load_chain();
    run(1, -1, -1, cyc, b1);
    total++; if (cyc !== 43) $display("FAIL und_done_cycle: got %0d expected 43", cyc); else passed++;
    total++; if (u_err !== 1'b0) $display("FAIL und_err: got %0d expected 0", u_err); else passed++;
    for (int c = 0; c < 3; c++) begin
      total++; if (dut_u.acc[0][c] !== 16'(6 * (c + 1))) $display("FAIL und_acc0[%0d]: got %0d expected %0d", c, dut_u.acc[0][c], 6 * (c + 1)); else passed++;
      total++; if (dut_u.acc[3][c] !== 16'(9 * (c + 1))) $display("FAIL und_acc3[%0d]: got %0d expected %0d", c, dut_u.acc[3][c], 9 * (c + 1)); else passed++;
    end
    for (int i = 0; i < 6; i++) begin
      total++; if (u_ans[i] !== 2'd2) $display("FAIL und_answer[%0d]: got %0d expected 2", i, u_ans[i]); else passed++;
    end
  endtask

  task automatic test_tie_self_edge();
    int cyc; logic b1;
    for (int i = 0; i < 8; i++) begin
      esrc[i] = 3'd2; edst[i] = 3'd2;
      rows[i][0] = 16'd7; rows[i][1] = 16'd7; rows[i][2] = 16'd1;
    end
    run(2, -1, -1, cyc, b1);
    total++; if (cyc !== 25) $display("FAIL tie_done_cycle: got %0d expected 25", cyc); else passed++;
    total++; if (dut_t.acc[2][0] !== 16'd42) $display("FAIL tie_acc2_0: got %0d expected 42", dut_t.acc[2][0]); else passed++;
    total++; if (dut_t.acc[2][1] !== 16'd42) $display("FAIL tie_acc2_1: got %0d expected 42", dut_t.acc[2][1]); else passed++;
    total++; if (dut_t.acc[2][2] !== 16'd6) $display("FAIL tie_acc2_2: got %0d expected 6", dut_t.acc[2][2]); else passed++;
    total++; if (dut_t.acc[0][0] !== 16'd0) $display("FAIL tie_acc0_0: got %0d expected 0", dut_t.acc[0][0]); else passed++;
    total++; if (t_ans[2] !== 2'd0) $display("FAIL tie_answer2: got %0d expected 0", t_ans[2]); else passed++;
  endtask

  task automatic load_sat();
    for (int i = 0; i < 8; i++) begin
      esrc[i] = 3'((i % 5) + 1); edst[i] = 3'd0;
      rows[i][0] = 16'hFFF0; rows[i][1] = 16'd1; rows[i][2] = 16'd0;
    end
  endtask

  task automatic test_saturation();
    int cyc; logic b1;
    load_sat();
    run(0, -1, -1, cyc, b1);
    total++; if (cyc !== 37) $display("FAIL sat_done_cycle: got %0d expected 37", cyc); else passed++;
    total++; if (dut_d.acc[0][0] !== 16'hFFFF) $display("FAIL sat_acc0_0: got %0h expected ffff", dut_d.acc[0][0]); else passed++;
    total++; if (dut_d.acc[0][1] !== 16'd7) $display("FAIL sat_acc0_1: got %0d expected 7", dut_d.acc[0][1]); else passed++;
    total++; if (dut_d.acc[3][0] !== 16'hFFF0) $display("FAIL sat_acc3_0: got %0h expected fff0", dut_d.acc[3][0]); else passed++;
    total++; if (d_ans[0] !== 2'd0) $display("FAIL sat_answer0: got %0d expected 0", d_ans[0]); else passed++;
  endtask

  task automatic test_wrap();
    int cyc; logic b1;
    load_sat();
    run(3, -1, -1, cyc, b1);
    total++; if (cyc !== 37) $display("FAIL wrap_done_cycle: got %0d expected 37", cyc); else passed++;
    total++; if (dut_w.acc[0][0] !== 16'hFF90) $display("FAIL wrap_acc0_0: got %0h expected ff90", dut_w.acc[0][0]); else passed++;
    total++; if (dut_w.acc[0][1] !== 16'd7) $display("FAIL wrap_acc0_1: got %0d expected 7", dut_w.acc[0][1]); else passed++;
    total++; if (w_ans[0] !== 2'd0) $display("FAIL wrap_answer0: got %0d expected 0", w_ans[0]); else passed++;
  endtask

  task automatic test_out_of_range();
    int cyc; logic b1;
    load_chain();
    esrc[3] = 3'd7;
    run(0, -1, -1, cyc, b1);
    total++; if (cyc !== 36) $display("FAIL oor_done_cycle: got %0d expected 36", cyc); else passed++;
    total++; if (d_err !== 1'b1) $display("FAIL oor_err: got %0d expected 1", d_err); else passed++;
    for (int c = 0; c < 3; c++) begin
      total++; if (dut_d.acc[4][c] !== 16'(4 * (c + 1))) $display("FAIL oor_acc4[%0d]: got %0d expected %0d", c, dut_d.acc[4][c], 4 * (c + 1)); else passed++;
      total++; if (dut_d.acc[5][c] !== 16'(9 * (c + 1))) $display("FAIL oor_acc5[%0d]: got %0d expected %0d", c, dut_d.acc[5][c], 9 * (c + 1)); else passed++;
    end
    total++; if (d_ans[4] !== 2'd2) $display("FAIL oor_answer4: got %0d expected 2", d_ans[4]); else passed++;
  endtask

  task automatic test_control();
    int cyc; logic b1;
    load_chain();
    run(0, 10, -1, cyc, b1);
    total++; if (cyc !== 37) $display("FAIL ctl_ignored_start_cycle: got %0d expected 37", cyc); else passed++;
    total++; if (d_err !== 1'b0) $display("FAIL ctl_err_cleared: got %0d expected 0", d_err); else passed++;
    total++; if (dut_d.acc[1][2] !== 16'd3) $display("FAIL ctl_acc1_2: got %0d expected 3", dut_d.acc[1][2]); else passed++;
    run(0, -1, 15, cyc, b1);
    total++; if (d_busy !== 1'b0) $display("FAIL abort_busy: got %0d expected 0", d_busy); else passed++;
    total++; if (d_done !== 1'b0) $display("FAIL abort_done: got %0d expected 0", d_done); else passed++;
    total++; if (d_read_en !== 1'b0) $display("FAIL abort_read_en: got %0d expected 0", d_read_en); else passed++;
    total++; if (d_coo_address !== 3'd0) $display("FAIL abort_coo_address: got %0d expected 0", d_coo_address); else passed++;
    total++; if (d_read_row !== 3'd0) $display("FAIL abort_read_row: got %0d expected 0", d_read_row); else passed++;
    total++; if (dut_d.acc[5][2] !== 16'd0) $display("FAIL abort_acc5_2: got %0d expected 0", dut_d.acc[5][2]); else passed++;
    for (int i = 0; i < 6; i++) begin
      total++; if (d_ans[i] !== 2'd0) $display("FAIL abort_answer[%0d]: got %0d expected 0", i, d_ans[i]); else passed++;
    end
    @(negedge clk);
    reset = 1'b1;
    run(0, -1, -1, cyc, b1);
    total++; if (cyc !== 37) $display("FAIL rerun_done_cycle: got %0d expected 37", cyc); else passed++;
    total++; if (d_done !== 1'b1) $display("FAIL rerun_done: got %0d expected 1", d_done); else passed++;
    for (int i = 0; i < 6; i++) begin
      total++; if (d_ans[i] !== 2'd2) $display("FAIL rerun_answer[%0d]: got %0d expected 2", i, d_ans[i]); else passed++;
    end
  endtask

  initial begin
    load_chain();
    test_reset();
    test_directed();
    test_undirected();
    test_tie_self_edge();
    test_saturation();
    test_wrap();
    test_out_of_range();
    test_control();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
